// File: rtl/alu_bcd_pkg.sv
// alu_bcd_pkg: shared definitions for the ALU / BCD display block.
//   - op_e    : operation codes driven on the op port
//   - state_e : controller states
//   - 7-segment constants (active-low, bit0..6 = a..g, bit7 = DP off)
package alu_bcd_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_CONV,
        ST_DONE
    } state_e;

    localparam int BCD_DIGITS = 5;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;

    // Entry [d] is the pattern for decimal digit d.
    localparam logic [9:0][7:0] SEG_DIGITS = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: combinational BCD digit to active-low 7-segment pattern.
//   bcd_i   : BCD digit 0..9 (codes above 9 show blank)
//   blank_i : force the digit dark
//   seg_o   : active-low segments, bit7 = DP (always off)
module seg7_encode
    import alu_bcd_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && (bcd_i <= 4'd9))
            seg_o = SEG_DIGITS[bcd_i];
    end

endmodule

// File: rtl/alu_bcd_display.sv
// alu_bcd_display: WIDTH-bit unsigned ALU (add, sub, sequential multiply,
// sequential restoring divide) with sequential double-dabble BCD conversion
// and six active-low 7-segment digit outputs.
//   CLK_50, rst      : clock, asynchronous active-high reset
//   en               : global enable, low freezes everything
//   start, op, A, B  : operation request (accepted only when idle)
//   busy, done       : status; done pulses when outputs update
//   result, neg, err : magnitude / quotient, negative flag, divide-by-zero
//   disp0..disp5     : digit outputs, disp0 least significant, disp5 sign
module alu_bcd_display
    import alu_bcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               CLK_50,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               neg,
    output logic               err,
    output logic [7:0]         disp0,
    output logic [7:0]         disp1,
    output logic [7:0]         disp2,
    output logic [7:0]         disp3,
    output logic [7:0]         disp4,
    output logic [7:0]         disp5
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(RW + 1);
    localparam logic [CW-1:0] CALC_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(RW);

    state_e          state_q;
    op_e             op_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   a_q;        // operand A; shifting multiplicand / dividend
    logic [WIDTH-1:0] b_q;       // operand B; shifting multiplier / divisor
    logic [RW-1:0]   res_q;      // sum, product or quotient under construction
    logic [WIDTH-1:0] rem_q;     // divide remainder
    logic            neg_c_q, err_c_q;
    logic [RW-1:0]   bin_q;
    logic [19:0]     bcd_q;
    logic            busy_q, done_q, neg_q, err_q;
    logic [RW-1:0]   result_q;
    logic [5:0][7:0] disp_q;

    logic [RW-1:0]   b_ext, diff, prod_nx, quo_nx, calc_res;
    logic            sub_neg, fits;
    logic [WIDTH:0]  trial;
    logic [WIDTH-1:0] rem_nx;
    logic [15:0]     adj;
    logic [BCD_DIGITS-1:0]      blank;
    logic [BCD_DIGITS-1:0][7:0] seg_w;

    assign b_ext = {{WIDTH{1'b0}}, b_q};

    // Arithmetic step logic for all operations.
    always_comb begin
        sub_neg = b_ext > a_q;
        diff    = sub_neg ? (b_ext - a_q) : (a_q - b_ext);
        prod_nx = res_q + (b_q[0] ? a_q : '0);
        trial   = {rem_q, a_q[WIDTH-1]};
        fits    = trial >= {1'b0, b_q};
        // When the trial does not fit it is below B, so its top bit is zero.
        rem_nx  = fits ? WIDTH'(trial - {1'b0, b_q}) : trial[WIDTH-1:0];
        quo_nx  = {res_q[RW-2:0], fits};
        case (op_q)
            OP_ADD:  calc_res = a_q + b_ext;
            OP_SUB:  calc_res = diff;
            OP_MUL:  calc_res = prod_nx;
            default: calc_res = quo_nx;
        endcase
    end

    // Double-dabble adjust. The top digit never needs it: the value is
    // below 100000, so that digit is at most 6 only after the final shift.
    always_comb begin
        adj = bcd_q[15:0];
        for (int i = 0; i < 4; i++)
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    // Leading-zero blanking; the units digit is always shown.
    always_comb begin
        logic z;
        z     = 1'b1;
        blank = '0;
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
            z        = z && (bcd_q[4*i +: 4] == 4'd0);
            blank[i] = z;
        end
    end

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_seg
        seg7_encode u_seg (
            .bcd_i   (bcd_q[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (seg_w[g])
        );
    end

    always_ff @(posedge CLK_50 or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            rem_q    <= '0;
            neg_c_q  <= 1'b0;
            err_c_q  <= 1'b0;
            bin_q    <= '0;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            disp_q   <= {{5{SEG_BLANK}}, SEG_DIGITS[0]};
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= RW'(A);
                        b_q     <= B;
                        op_q    <= op_e'(op);
                        res_q   <= '0;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        neg_c_q <= 1'b0;
                        err_c_q <= 1'b0;
                        busy_q  <= 1'b1;
                        neg_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (op_q == OP_DIV && b_q == '0) begin
                        // Divide by zero: land on the final CONV cycle so the
                        // next edge reports the error without converting.
                        err_c_q <= 1'b1;
                        res_q   <= '0;
                        cnt_q   <= CONV_LAST;
                        state_q <= ST_CONV;
                    end else begin
                        if (op_q == OP_MUL) begin
                            a_q <= a_q << 1;
                            b_q <= b_q >> 1;
                        end else if (op_q == OP_DIV) begin
                            a_q   <= a_q << 1;
                            rem_q <= rem_nx;
                        end
                        res_q <= calc_res;
                        if (op_q == OP_ADD || op_q == OP_SUB || cnt_q == CALC_LAST) begin
                            neg_c_q <= (op_q == OP_SUB) && sub_neg;
                            bin_q   <= calc_res;
                            bcd_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_CONV;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_CONV: begin
                    if (cnt_q == CONV_LAST) begin
                        done_q   <= 1'b1;
                        result_q <= res_q;
                        neg_q    <= neg_c_q;
                        err_q    <= err_c_q;
                        if (err_c_q)
                            disp_q <= {{5{SEG_BLANK}}, SEG_E};
                        else
                            disp_q <= {neg_c_q ? SEG_MINUS : SEG_BLANK, seg_w};
                        state_q  <= ST_DONE;
                    end else begin
                        bcd_q <= {bcd_q[18:16], adj, bin_q[RW-1]};
                        bin_q <= bin_q << 1;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign neg    = neg_q;
    assign err    = err_q;
    assign disp0  = disp_q[0];
    assign disp1  = disp_q[1];
    assign disp2  = disp_q[2];
    assign disp3  = disp_q[3];
    assign disp4  = disp_q[4];
    assign disp5  = disp_q[5];

endmodule

// File: tb/tb_alu_bcd_display.sv
module tb_alu_bcd_display;
    localparam int W = 8;

    logic           CLK_50 = 1'b0;
    logic           rst = 1'b1, en = 1'b0, start = 1'b0;
    logic [1:0]     op = '0;
    logic [W-1:0]   A = '0, B = '0;
    logic           busy, done, neg, err;
    logic [2*W-1:0] result;
    logic [7:0]     disp0, disp1, disp2, disp3, disp4, disp5;
    logic [7:0]     dv [6];

    int n_run = 0;
    int n_fail = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    assign dv[0] = disp0;
    assign dv[1] = disp1;
    assign dv[2] = disp2;
    assign dv[3] = disp3;
    assign dv[4] = disp4;
    assign dv[5] = disp5;

    alu_bcd_display #(.WIDTH(W)) dut (
        .CLK_50 (CLK_50), .rst (rst), .en (en), .start (start), .op (op),
        .A (A), .B (B), .busy (busy), .done (done), .result (result),
        .neg (neg), .err (err), .disp0 (disp0), .disp1 (disp1),
        .disp2 (disp2), .disp3 (disp3), .disp4 (disp4), .disp5 (disp5)
    );

    always #10 CLK_50 = ~CLK_50;

    task automatic tick();
        @(posedge CLK_50);
        #1;
    endtask

    // Behavioural reference: result, flags and latency from plain arithmetic.
    function automatic void ref_model(input int o, input int a, input int b,
                                      output int unsigned r, output bit ng,
                                      output bit er, output int lat);
        ng = 1'b0;
        er = 1'b0;
        r  = 0;
        case (o)
            0: r = a + b;
            1: begin ng = (b > a); r = ng ? b - a : a - b; end
            2: r = a * b;
            default: if (b == 0) er = 1'b1; else r = a / b;
        endcase
        lat = er ? 2 : 1 + ((o >= 2) ? W : 1) + 2 * W;
    endfunction

    function automatic logic [7:0] exp_disp(input int idx, input int unsigned r,
                                            input bit ng, input bit er);
        int unsigned p;
        if (er) return (idx == 0) ? 8'h86 : 8'hFF;
        if (idx == 5) return ng ? 8'hBF : 8'hFF;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        if (idx != 0 && r < p) return 8'hFF;
        return seg_tab[(r / p) % 10];
    endfunction

    // Issue one operation and count edges after the accepting edge until done.
    task automatic run_op(input int o, input int a, input int b,
                          input int stall_at, input int stall_len,
                          input int poke_at, output int edges);
        op = 2'(o); A = W'(a); B = W'(b); en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble inputs so any re-latch after accept would corrupt the result.
        A = W'($urandom); B = W'($urandom); op = 2'($urandom);
        edges = 0;
        for (int k = 0; k < 400; k++) begin
            en    = !(edges >= stall_at && edges < stall_at + stall_len);
            start = (edges + 1 == poke_at);
            tick();
            edges++;
            if (done) break;
        end
        start = 1'b0;
        en = 1'b1;
        if (!done) edges = -1;
    endtask

    task automatic test_reset();
        #15;
        n_run++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++;
            $display("FAIL reset_status busy=%b done=%b required 0 0", busy, done); end
        n_run++; if (result !== '0 || neg !== 1'b0 || err !== 1'b0) begin n_fail++;
            $display("FAIL reset_result result=%0d neg=%b err=%b required 0 0 0", result, neg, err); end
        for (int i = 0; i < 6; i++) begin
            n_run++;
            if (dv[i] !== ((i == 0) ? 8'hC0 : 8'hFF)) begin n_fail++;
                $display("FAIL reset_disp%0d got %h required %h", i, dv[i], (i == 0) ? 8'hC0 : 8'hFF); end
        end
        @(negedge CLK_50);
        rst = 1'b0;
        en = 1'b0; start = 1'b1; op = 2'd0; A = 8'd1; B = 8'd1;
        repeat (3) tick();
        n_run++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++;
            $display("FAIL start_with_en_low busy=%b done=%b required 0 0", busy, done); end
        start = 1'b0; en = 1'b1;
        repeat (2) tick();
        n_run++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL start_with_en_low_later busy=%b required 0", busy); end
    endtask

    task automatic test_ops(input int n_random);
        int d_op [6] = '{0, 0, 2, 1, 3, 3};
        int d_a  [6] = '{5, 0, 255, 3, 200, 7};
        int d_b  [6] = '{5, 0, 255, 200, 7, 0};
        int o, a, b, lat, edges;
        int unsigned r;
        bit ng, er;
        for (int i = 0; i < 6 + n_random; i++) begin
            if (i < 6) begin
                o = d_op[i]; a = d_a[i]; b = d_b[i];
            end else begin
                o = int'($urandom_range(0, 3));
                a = int'($urandom_range(0, 255));
                b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
            end
            ref_model(o, a, b, r, ng, er, lat);
            // The multiply case also gets a start pulse at edge 5, to be ignored.
            run_op(o, a, b, 0, 0, (i == 2) ? 5 : 0, edges);
            n_run++; if (edges != lat) begin n_fail++;
                $display("FAIL op%0d_latency op=%0d a=%0d b=%0d got %0d edges required %0d", i, o, a, b, edges, lat); end
            if (!er) begin
                n_run++; if (result !== 16'(r)) begin n_fail++;
                    $display("FAIL op%0d_result op=%0d a=%0d b=%0d got %0d required %0d", i, o, a, b, result, r); end
            end
            n_run++; if (neg !== ng || err !== er) begin n_fail++;
                $display("FAIL op%0d_flags neg=%b err=%b required %b %b", i, neg, err, ng, er); end
            for (int d = 0; d < 6; d++) begin
                n_run++; if (dv[d] !== exp_disp(d, r, ng, er)) begin n_fail++;
                    $display("FAIL op%0d_disp%0d op=%0d a=%0d b=%0d got %h required %h", i, d, o, a, b, dv[d], exp_disp(d, r, ng, er)); end
            end
            n_run++; if (busy !== 1'b1) begin n_fail++;
                $display("FAIL op%0d_busy_at_done got %b required 1", i, busy); end
            tick();
            n_run++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++;
                $display("FAIL op%0d_after_done done=%b busy=%b required 0 0", i, done, busy); end
        end
    endtask

    task automatic test_stall();
        int edges;
        run_op(2, 200, 123, 3, 5, 0, edges);
        n_run++; if (edges != 25 + 5) begin n_fail++;
            $display("FAIL stall_latency got %0d edges required 30", edges); end
        n_run++; if (result !== 16'd24600) begin n_fail++;
            $display("FAIL stall_result got %0d required 24600", result); end
        n_run++; if (dv[4] !== 8'hA4 || dv[0] !== 8'hC0) begin n_fail++;
            $display("FAIL stall_disp got %h..%h required a4..c0", dv[4], dv[0]); end
        tick();
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        op = 2'd2; A = 8'd99; B = 8'd77; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();   // well inside the conversion phase
        n_run++; if (busy !== 1'b1) begin n_fail++;
            $display("FAIL abort_busy_before got %b required 1", busy); end
        #5 rst = 1'b1;
        #1;
        n_run++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin n_fail++;
            $display("FAIL abort_status busy=%b done=%b result=%0d required 0 0 0", busy, done, result); end
        for (int i = 0; i < 6; i++) begin
            n_run++; if (dv[i] !== ((i == 0) ? 8'hC0 : 8'hFF)) begin n_fail++;
                $display("FAIL abort_disp%0d got %h required %h", i, dv[i], (i == 0) ? 8'hC0 : 8'hFF); end
        end
        @(negedge CLK_50);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        n_run++; if (saw_done || busy !== 1'b0) begin n_fail++;
            $display("FAIL abort_no_done saw_done=%b busy=%b required 0 0", saw_done, busy); end
    endtask

    initial begin
        test_reset();
        test_ops(30);
        test_stall();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_bcd_display.md
Name: alu_bcd_display

Overview:
- Parametrised successor to the 3-bit ALU display top level.
- Takes WIDTH-bit operands and performs add, subtract, sequential shift-add multiply or sequential restoring divide.
- Converts the result magnitude to BCD with a sequential double-dabble.
- Drives six active-low 7-segment digits, with sign, error indication and leading-zero blanking.
- Sits between board switches/keys and the HEX displays, running on the 50 MHz board clock.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 3..8, so the magnitude of 2*WIDTH bits fits in 5 decimal digits.

Ports:
- CLK_50  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; low stalls all state and counters
- start  in  1  request a new operation; sampled only in IDLE with en=1
- op  in  2  00 add, 01 sub, 10 mul, 11 div
- A  in  WIDTH  operand A, unsigned
- B  in  WIDTH  operand B, unsigned
- busy  out  1  high from accept until the cycle after done
- done  out  1  one-cycle pulse when result and displays update
- result  out  2*WIDTH  result magnitude (quotient for div)
- neg  out  1  result negative (sub with B>A)
- err  out  1  divide by zero
- disp0..disp5  out  8 each  7-seg, active-low, bit0..6 = a..g, bit7 = DP (always 1); disp0 = least significant digit

Behaviour:
- One clock: CLK_50. Reset is asynchronous and active-high, port rst.
- Reset values: result=0, neg=0, err=0, busy=0, done=0, disp0=8'hC0 ("0"), disp1..disp5=8'hFF (blank), FSM=IDLE.
- Reset mid-operation aborts immediately. No done pulse follows.
- Segment codes: 0..9 = C0 F9 A4 B0 99 92 82 F8 80 90. Minus = BF. E = 86. Blank = FF.
- FSM states: IDLE -> CALC -> CONV -> DONE -> IDLE.
- IDLE:
  - On an edge with start=1 and en=1: latch A, B, op; set busy=1; clear neg and err; go to CALC.
  - start while busy is ignored.
- CALC:
  - add/sub: 1 cycle. Sub computes |A-B| and sets neg=1 iff B>A.
  - mul: WIDTH cycles, one partial product per cycle.
  - div: WIDTH cycles, one quotient bit per cycle.
  - div with B=0: 1 cycle, set err=1, skip CONV, go to DONE.
- CONV: double-dabble over 2*WIDTH cycles, one bit per cycle (add 3 to any nibble >=5, then shift).
- DONE (1 cycle):
  - done=1; result, neg, err and displays are updated from registers entered at this edge.
  - Next edge: busy=0, go to IDLE.
- Latency: done is high in the cycle after the (1 + C + 2*WIDTH)-th edge following the accepting edge.
  - C = 1 for add/sub, C = WIDTH for mul/div.
  - Divide by zero: done after the 2nd edge.
  - WIDTH=8 examples: add = 18 edges, mul = 25 edges.
- en=0:
  - FSM, datapath and counters hold; done stays low.
  - Latency extends by exactly the number of stalled cycles.
  - An en=0 cycle in DONE holds done high.
- Display rules:
  - disp0..disp4 show the 5 BCD digits.
  - Digits above the most significant nonzero digit are blank; disp0 is always shown (result 0 shows "0").
  - disp5 = BF when neg=1, else FF.
  - err=1: disp0=86, all others FF.
  - Displays hold their values until the next DONE.
- Arithmetic is unsigned. Overflow is impossible: add needs ≤ WIDTH+1 bits, mul ≤ 2*WIDTH bits.

Decomposition:
- Package alu_bcd_pkg holds:
  - op codes OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - FSM state encoding
  - segment constants SEG_BLANK, SEG_MINUS, SEG_E, and the digit table
- Sub-module seg7_encode: combinational, 4-bit BCD plus blank flag -> 8-bit active-low pattern. Instantiated 5 times.

Test Plan:
1. Reset: assert rst mid-cycle -> outputs take reset values immediately (disp0=C0, others FF, busy=0). Release rst, pulse start with en=0 -> nothing happens.
2. WIDTH=8, add A=5, B=5 -> done after 18 edges, result=10, disp1=F9, disp0=C0, disp2..5=FF. Repeat with A=B=0 -> disp0=C0 only.
3. mul A=255, B=255 -> done after 25 edges, result=65025, disp4..0 = 82 92 C0 A4 92. A start pulse at edge 5 is ignored.
4. sub A=3, B=200 -> neg=1, result=197, disp5=BF, disp2..0 = F9 90 F8, disp3 and disp4 = FF.
5. div A=200, B=7 -> result=28, disp1..0 = A4 80. div A=7, B=0 -> err=1, done after 2 edges, disp0=86, rest FF.
6. mul with en low for 5 cycles mid-CALC -> done after 30 edges with the correct result. A second run with rst pulsed during CONV -> no done pulse and displays return to reset values.
